cbs_core: RTL and testbench

- Single-cycle 32-bit load/store core: one instruction fetched, decoded, executed and retired per clock.
- Contains the PC, instruction memory, decoder (opd_32 function), register file, ALU (alu function), data memory and branch comparator (cmp function).
- It is the top-level execution core; memories are preloaded through a programming port, and state is observable through debug ports.

---
 rtl/cbs_core.sv | 219 +++++++++++++++++++++
 tb/tb_cbs_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbs_core.sv
// cbs_core: single-cycle 32-bit load/store execution core.
// Each clock, one instruction is fetched from the instruction memory,
// decoded, executed and retired.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            asynchronous active-low reset (clears PC and registers)
//   i_prog_we      programming write strobe
//   i_prog_target  0 = instruction memory, 1 = data memory
//   i_prog_addr    programming word index (out-of-range ignored)
//   i_prog_data    programming write data
//   i_dbg_reg_sel  debug register index
//   o_dbg_reg      register word at i_dbg_reg_sel (combinational)
//   i_dbg_mem_sel  debug data memory index
//   o_dbg_mem      data memory word at i_dbg_mem_sel (combinational)
//   o_pc           current PC
//   o_instr        current instruction
//   o_alu          current ALU result
module cbs_core #(
    parameter int  NUM_REG   = 5,
    parameter int  REG_WIDTH = 32,
    parameter int  NUM_INSTR = 10,
    parameter int  NUM_MEM   = 5,
    localparam int RS        = $clog2(NUM_REG),
    localparam int PCW       = $clog2(NUM_INSTR),
    localparam int MS        = $clog2(NUM_MEM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_prog_we,
    input  logic                 i_prog_target,
    input  logic [REG_WIDTH-1:0] i_prog_addr,
    input  logic [REG_WIDTH-1:0] i_prog_data,
    input  logic [RS-1:0]        i_dbg_reg_sel,
    output logic [REG_WIDTH-1:0] o_dbg_reg,
    input  logic [MS-1:0]        i_dbg_mem_sel,
    output logic [REG_WIDTH-1:0] o_dbg_mem,
    output logic [PCW-1:0]       o_pc,
    output logic [REG_WIDTH-1:0] o_instr,
    output logic [REG_WIDTH-1:0] o_alu
);

    localparam int IMMW = REG_WIDTH - 6 - 3 * RS;

    typedef enum logic [5:0] {
        OP_NOP = 6'b000000,
        OP_ADD = 6'b000001,
        OP_SUB = 6'b000010,
        OP_AND = 6'b000011,
        OP_OR  = 6'b000100,
        OP_XOR = 6'b000101,
        OP_SLT = 6'b000110,
        OP_SLL = 6'b000111,
        OP_SRL = 6'b001000,
        OP_LW  = 6'b010000,
        OP_SW  = 6'b010001,
        OP_BEQ = 6'b100000,
        OP_BNE = 6'b100001,
        OP_BLT = 6'b100010,
        OP_BGE = 6'b100011
    } opcode_e;

    typedef struct packed {
        logic [5:0]           op;
        logic [RS-1:0]        a;
        logic [RS-1:0]        b;
        logic [RS-1:0]        c;
        logic [REG_WIDTH-1:0] imm;
    } dec_t;

    logic [REG_WIDTH-1:0] r_regs [NUM_REG];
    logic [REG_WIDTH-1:0] r_imem [NUM_INSTR];
    logic [REG_WIDTH-1:0] r_dmem [NUM_MEM];
    logic [PCW-1:0]       r_pc;

    logic [REG_WIDTH-1:0] w_instr;
    dec_t                 w_dec;
    logic [REG_WIDTH-1:0] w_ra;
    logic [REG_WIDTH-1:0] w_rb;
    logic [REG_WIDTH-1:0] w_alu;
    logic                 w_taken;
    logic [PCW-1:0]       w_next_pc;
    logic [MS-1:0]        w_mem_addr;
    logic                 w_mem_ok;
    logic [REG_WIDTH-1:0] w_ld_data;
    logic                 w_reg_we;
    logic [REG_WIDTH-1:0] w_wdata;
    logic                 w_st_we;
    logic                 w_prog_imem;
    logic                 w_prog_dmem;

    // Field split MSB first: opcode, A, B, C, then a sign-extended immediate.
    function automatic dec_t opd_32(input logic [REG_WIDTH-1:0] ins);
        dec_t d;
        d.op  = ins[REG_WIDTH-1 -: 6];
        d.a   = ins[REG_WIDTH-7 -: RS];
        d.b   = ins[REG_WIDTH-7-RS -: RS];
        d.c   = ins[REG_WIDTH-7-2*RS -: RS];
        d.imm = {{(REG_WIDTH-IMMW){ins[IMMW-1]}}, ins[IMMW-1:0]};
        return d;
    endfunction

    // Memory ops compute the effective address; branches compute the target.
    function automatic logic [REG_WIDTH-1:0] alu(
        input logic [5:0]           op,
        input logic [REG_WIDTH-1:0] a,
        input logic [REG_WIDTH-1:0] b,
        input logic [REG_WIDTH-1:0] imm,
        input logic [REG_WIDTH-1:0] pcx
    );
        logic [REG_WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:                         r = a + b;
            OP_SUB:                         r = a - b;
            OP_AND:                         r = a & b;
            OP_OR:                          r = a | b;
            OP_XOR:                         r = a ^ b;
            OP_SLT:                         r[0] = ($signed(a) < $signed(b));
            OP_SLL:                         r = a << b[4:0];
            OP_SRL:                         r = a >> b[4:0];
            OP_LW, OP_SW:                   r = a + imm;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE: r = pcx + imm;
            default:                        r = '0;
        endcase
        return r;
    endfunction

    function automatic logic cmp(
        input logic [5:0]           op,
        input logic [REG_WIDTH-1:0] a,
        input logic [REG_WIDTH-1:0] b
    );
        logic t;
        t = 1'b0;
        case (op)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = ($signed(a) <  $signed(b));
            OP_BGE:  t = ($signed(a) >= $signed(b));
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    always_comb begin
        w_instr = '0;
        if (32'(r_pc) < 32'(NUM_INSTR)) begin
            w_instr = r_imem[r_pc];
        end
        w_dec = opd_32(w_instr);

        w_ra = '0;
        w_rb = '0;
        if (32'(w_dec.a) < 32'(NUM_REG)) w_ra = r_regs[w_dec.a];
        if (32'(w_dec.b) < 32'(NUM_REG)) w_rb = r_regs[w_dec.b];

        w_alu     = alu(w_dec.op, w_ra, w_rb, w_dec.imm, REG_WIDTH'(r_pc));
        w_taken   = cmp(w_dec.op, w_ra, w_rb);
        w_next_pc = w_taken ? w_alu[PCW-1:0] : r_pc + PCW'(1);

        w_mem_addr = w_alu[MS-1:0];
        w_mem_ok   = (32'(w_mem_addr) < 32'(NUM_MEM));
        w_ld_data  = '0;
        if (w_mem_ok) w_ld_data = r_dmem[w_mem_addr];

        w_reg_we = 1'b0;
        case (w_dec.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLT, OP_SLL, OP_SRL, OP_LW: w_reg_we = (32'(w_dec.c) < 32'(NUM_REG));
            default:                       w_reg_we = 1'b0;
        endcase
        w_wdata = (w_dec.op == OP_LW) ? w_ld_data : w_alu;
        w_st_we = (w_dec.op == OP_SW) && w_mem_ok;

        w_prog_imem = i_prog_we && !i_prog_target && (i_prog_addr < REG_WIDTH'(NUM_INSTR));
        w_prog_dmem = i_prog_we &&  i_prog_target && (i_prog_addr < REG_WIDTH'(NUM_MEM));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= '0;
            for (int unsigned i = 0; i < NUM_REG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_pc <= w_next_pc;
            if (w_reg_we) begin
                r_regs[w_dec.c] <= w_wdata;
            end
        end
    end

    // Memories are never reset. The programming write is issued after the
    // core store so that it wins when both target the same word.
    always_ff @(posedge clk) begin
        if (rst && w_st_we) begin
            r_dmem[w_mem_addr] <= w_rb;
        end
        if (w_prog_dmem) begin
            r_dmem[i_prog_addr[MS-1:0]] <= i_prog_data;
        end
        if (w_prog_imem) begin
            r_imem[i_prog_addr[PCW-1:0]] <= i_prog_data;
        end
    end

    always_comb begin
        o_dbg_reg = '0;
        o_dbg_mem = '0;
        if (32'(i_dbg_reg_sel) < 32'(NUM_REG)) o_dbg_reg = r_regs[i_dbg_reg_sel];
        if (32'(i_dbg_mem_sel) < 32'(NUM_MEM)) o_dbg_mem = r_dmem[i_dbg_mem_sel];
    end

    assign o_pc    = r_pc;
    assign o_instr = w_instr;
    assign o_alu   = w_alu;

endmodule

// File: tb/tb_cbs_core.sv
// Testbench for cbs_core: expected results are pushed to a scoreboard queue
// before each clock and popped/compared once the DUT has produced them.
module tb_cbs_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_prog_we = 1'b0;
    logic        i_prog_target = 1'b0;
    logic [31:0] i_prog_addr = '0;
    logic [31:0] i_prog_data = '0;
    logic [2:0]  i_dbg_reg_sel = '0;
    logic [2:0]  i_dbg_mem_sel = '0;
    logic [31:0] o_dbg_reg;
    logic [31:0] o_dbg_mem;
    logic [3:0]  o_pc;
    logic [31:0] o_instr;
    logic [31:0] o_alu;

    cbs_core #(
        .NUM_REG   (5),
        .REG_WIDTH (32),
        .NUM_INSTR (10),
        .NUM_MEM   (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_prog_we     (i_prog_we),
        .i_prog_target (i_prog_target),
        .i_prog_addr   (i_prog_addr),
        .i_prog_data   (i_prog_data),
        .i_dbg_reg_sel (i_dbg_reg_sel),
        .o_dbg_reg     (o_dbg_reg),
        .i_dbg_mem_sel (i_dbg_mem_sel),
        .o_dbg_mem     (o_dbg_mem),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .o_alu         (o_alu)
    );

    always #50 clk = ~clk;

    localparam logic [5:0] NOP = 6'b000000, ADD = 6'b000001, SUB = 6'b000010;
    localparam logic [5:0] SLT = 6'b000110, SRL = 6'b001000;
    localparam logic [5:0] LW  = 6'b010000, SW  = 6'b010001;
    localparam logic [5:0] BEQ = 6'b100000, BNE = 6'b100001, BLT = 6'b100010;

    localparam int K_PC = 0, K_REG = 1, K_MEM = 2, K_ALU = 3, K_INSTR = 4;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    function automatic logic [31:0] enc(logic [5:0] op, int a, int b, int c, int imm);
        logic [31:0] w;
        w = {op, 3'(a), 3'(b), 3'(c), 17'(imm)};
        return w;
    endfunction

    task automatic sb_push(int kind, int idx, logic [31:0] v, string name);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic observe(input exp_t e, output logic [31:0] got);
        got = 'x;
        case (e.kind)
            K_PC:    begin #1; got = 32'(o_pc); end
            K_REG:   begin i_dbg_reg_sel = 3'(e.idx); #1; got = o_dbg_reg; end
            K_MEM:   begin i_dbg_mem_sel = 3'(e.idx); #1; got = o_dbg_mem; end
            K_ALU:   begin #1; got = o_alu; end
            K_INSTR: begin #1; got = o_instr; end
            default: got = 'x;
        endcase
    endtask

    task automatic prog(bit tgt, int addr, logic [31:0] d);
        i_prog_we     = 1'b1;
        i_prog_target = tgt;
        i_prog_addr   = 32'(addr);
        i_prog_data   = d;
        @(negedge clk);
        i_prog_we     = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] got;
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) prog(1'b0, i, 32'h0);
        sb_push(K_PC, 0, 32'd0, "reset_pc");
        for (int r = 0; r < 5; r++) sb_push(K_REG, r, 32'd0, $sformatf("reset_r%0d", r));
        for (int cyc = 0; cyc <= 16; cyc++) begin
            if (cyc > 0) begin
                sb_push(K_PC, 0, 32'(cyc % 16), $sformatf("nop_pc_c%0d", cyc));
                if (cyc == 12) sb_push(K_INSTR, 0, 32'd0, "fetch_oob_instr");
                @(negedge clk);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e, got);
                n_chk++;
                if (got !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
                end
            end
            if (cyc == 0) rst = 1'b1;
        end
    endtask

    task automatic test_load_chain();
        exp_t e;
        logic [31:0] got;
        rst = 1'b0;
        prog(1'b1, 0, 32'd1);
        prog(1'b1, 1, 32'd2);
        prog(1'b1, 2, 32'hFFFF_FFFF);
        prog(1'b1, 4, 32'h55);
        prog(1'b0, 0, enc(LW, 0, 0, 4, 0));
        prog(1'b0, 1, enc(LW, 0, 0, 0, 0));
        prog(1'b0, 2, enc(LW, 0, 0, 1, 0));
        prog(1'b0, 3, enc(ADD, 1, 0, 2, 0));
        prog(1'b0, 4, enc(SW, 2, 2, 0, 0));
        prog(1'b0, 5, enc(BEQ, 2, 2, 0, 3));
        prog(1'b0, 6, enc(NOP, 0, 0, 0, 0));
        prog(1'b0, 7, enc(NOP, 0, 0, 0, 0));
        prog(1'b0, 8, enc(ADD, 1, 0, 2, 0));
        prog(1'b0, 9, enc(NOP, 0, 0, 0, 0));
        sb_push(K_PC, 0, 32'd0, "lc_pc0");
        sb_push(K_INSTR, 0, enc(LW, 0, 0, 4, 0), "lc_instr0");
        sb_push(K_ALU, 0, 32'd0, "lc_alu0");
        for (int cyc = 0; cyc <= 4; cyc++) begin
            case (cyc)
                1: begin sb_push(K_REG, 4, 32'd1, "lw_r4"); sb_push(K_PC, 0, 32'd1, "lc_pc1"); end
                2: begin sb_push(K_REG, 0, 32'd1, "lw_r0"); sb_push(K_PC, 0, 32'd2, "lc_pc2"); end
                3: begin sb_push(K_REG, 1, 32'd2, "lw_r1"); sb_push(K_ALU, 0, 32'd3, "add_alu"); end
                4: begin sb_push(K_REG, 2, 32'd3, "add_r2"); sb_push(K_PC, 0, 32'd4, "lc_pc4"); end
                default: ;
            endcase
            if (cyc > 0) @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e, got);
                n_chk++;
                if (got !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
                end
            end
            if (cyc == 0) rst = 1'b1;
        end
    endtask

    task automatic test_store();
        exp_t e;
        logic [31:0] got;
        logic [31:0] regs_exp [5];
        regs_exp = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        sb_push(K_ALU, 0, 32'd3, "sw_addr_alu");
        sb_push(K_MEM, 3, 32'd3, "sw_dmem3");
        sb_push(K_MEM, 0, 32'd1, "sw_dmem0_kept");
        sb_push(K_MEM, 1, 32'd2, "sw_dmem1_kept");
        for (int r = 0; r < 5; r++) sb_push(K_REG, r, regs_exp[r], $sformatf("sw_r%0d_kept", r));
        sb_push(K_PC, 0, 32'd5, "sw_pc");
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == K_ALU) continue;
            observe(e, got);
            n_chk++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
            end
        end
    endtask

    task automatic test_branch_taken();
        exp_t e;
        logic [31:0] got;
        for (int cyc = 0; cyc <= 2; cyc++) begin
            case (cyc)
                0: sb_push(K_ALU, 0, 32'd8, "beq_target_alu");
                1: begin sb_push(K_PC, 0, 32'd8, "beq_taken_pc"); sb_push(K_ALU, 0, 32'd3, "add8_alu"); end
                2: begin sb_push(K_REG, 2, 32'd3, "add8_r2"); sb_push(K_PC, 0, 32'd9, "add8_pc"); end
                default: ;
            endcase
            if (cyc > 0) @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e, got);
                n_chk++;
                if (got !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
                end
            end
        end
    endtask

    task automatic test_branch_not_taken();
        exp_t e;
        logic [31:0] got;
        rst = 1'b0;
        prog(1'b0, 5, enc(BNE, 2, 2, 0, 3));
        prog(1'b0, 6, enc(LW, 0, 0, 3, 1));
        prog(1'b0, 7, enc(BLT, 3, 0, 0, 2));
        prog(1'b0, 8, enc(ADD, 1, 0, 2, 0));
        prog(1'b0, 9, enc(ADD, 3, 4, 3, 0));
        rst = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            case (cyc)
                5: sb_push(K_PC, 0, 32'd5, "bnt_pc5");
                6: begin sb_push(K_PC, 0, 32'd6, "bne_not_taken_pc"); sb_push(K_ALU, 0, 32'd2, "lw_m1_alu"); end
                7: begin sb_push(K_REG, 3, 32'hFFFF_FFFF, "lw_m1_r3"); sb_push(K_ALU, 0, 32'd9, "blt_target_alu"); end
                8: begin sb_push(K_PC, 0, 32'd9, "blt_taken_pc"); sb_push(K_ALU, 0, 32'd0, "add_wrap_alu"); end
                9: begin sb_push(K_REG, 3, 32'd0, "add_wrap_r3"); sb_push(K_INSTR, 0, 32'd0, "pc10_instr"); end
                default: sb_push(K_PC, 0, 32'(cyc), $sformatf("bnt_pc%0d", cyc));
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e, got);
                n_chk++;
                if (got !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
                end
            end
        end
    endtask

    task automatic test_boundaries();
        exp_t e;
        logic [31:0] got;
        logic [31:0] dm_exp [5];
        dm_exp = '{32'd1, 32'd2, 32'hFFFF_FFFF, 32'd3, 32'h55};
        rst = 1'b0;
        prog(1'b0, 0, enc(LW, 0, 0, 1, 3));
        prog(1'b0, 1, enc(LW, 0, 0, 1, 6));
        prog(1'b0, 2, enc(LW, 0, 0, 2, 1));
        prog(1'b0, 3, enc(SW, 0, 2, 0, 7));
        prog(1'b0, 4, enc(SUB, 0, 2, 3, 0));
        prog(1'b0, 5, enc(SLT, 3, 0, 4, 0));
        prog(1'b0, 6, enc(SRL, 3, 4, 0, 0));
        for (int i = 7; i < 10; i++) prog(1'b0, i, enc(NOP, 0, 0, 0, 0));
        rst = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            case (cyc)
                1: begin sb_push(K_REG, 1, 32'd3, "lw3_r1"); sb_push(K_ALU, 0, 32'd6, "lw6_alu"); end
                2: sb_push(K_REG, 1, 32'd0, "lw6_oob_r1");
                3: begin sb_push(K_REG, 2, 32'd2, "lw1_r2"); sb_push(K_ALU, 0, 32'd7, "sw7_alu"); end
                4: for (int m = 0; m < 5; m++) sb_push(K_MEM, m, dm_exp[m], $sformatf("sw7_dmem%0d", m));
                5: sb_push(K_REG, 3, 32'hFFFF_FFFE, "sub_r3");
                6: sb_push(K_REG, 4, 32'd1, "slt_r4");
                7: sb_push(K_REG, 0, 32'h7FFF_FFFF, "srl_r0");
                8: begin
                    #10 rst = 1'b0;
                    #1;
                    sb_push(K_PC, 0, 32'd0, "async_pc");
                    for (int r = 0; r < 5; r++) sb_push(K_REG, r, 32'd0, $sformatf("async_r%0d", r));
                    sb_push(K_MEM, 3, 32'd3, "async_dmem3");
                    sb_push(K_MEM, 4, 32'h55, "async_dmem4");
                    sb_push(K_INSTR, 0, enc(LW, 0, 0, 1, 3), "async_imem0");
                end
                default: ;
            endcase
            if (cyc < 8) @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e, got);
                n_chk++;
                if (got !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_chain();
        test_store();
        test_branch_taken();
        test_branch_not_taken();
        test_boundaries();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
